// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO decoupling a bursty producer from uart_transmitter's valid/ready drain.
//   clk_i        system clock, all state on rising edge
//   nrst_i       synchronous active-low reset, clears both pointers
//   in_valid_i   producer offers in_data_i
//   in_data_i    byte to enqueue
//   in_ready_o   byte accepted this cycle (low while full or in reset)
//   out_valid_o  head byte available on out_data_o
//   out_data_o   head byte (combinational read)
//   out_ready_i  consumer takes the head this cycle
//   count_o      stored entries, 0..DEPTH
//   empty_o      count_o == 0
//   full_o       count_o == DEPTH
// Optional UART_TX_FIFO_BYPASS_EN: when empty, in_* cuts straight through to out_*.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [7:0]    out_data_o,
  input  logic          out_ready_i,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        push, pop, cut;
  always_comb begin
    empty_o    = wr_ptr_q == rd_ptr_q;
    full_o     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    count_o    = wr_ptr_q - rd_ptr_q;
    in_ready_o = nrst_i & ~full_o;
`ifdef UART_TX_FIFO_BYPASS_EN
    out_valid_o = empty_o ? in_valid_i : 1'b1;
    out_data_o  = empty_o ? in_data_i : mem_q[rd_ptr_q[AW-1:0]];
    // a byte consumed straight through an empty FIFO is never stored
    cut         = empty_o & in_valid_i & out_ready_i;
`else
    out_valid_o = ~empty_o;
    out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    cut         = 1'b0;
`endif
    push     = in_valid_i & in_ready_o & ~cut;
    pop      = out_valid_o & out_ready_i & ~empty_o;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo (DEPTH=16).
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       nrst, in_valid, in_ready, out_valid, out_ready, empty, full;
  logic [7:0] in_data, out_data;
  logic [4:0] count;
  int         tests = 0, fails = 0;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk_i(clk), .nrst_i(nrst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] hello [5];
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    nrst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    nrst = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    // fill with 0x00..0x0F, consumer stalled
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      chk("fill_count", count, i + 1);
    end
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_data, 8'h00);
    in_data = 8'hAA;
    tick();
    chk("overflow_count", count, 16);
    in_valid = 1'b0;
    // drain
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, i);
      tick();
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 0);
    out_ready = 1'b0;
    // preload 5, then push and pop together for 40 cycles
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      tick();
    end
    chk("pre5_count", count, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = 8'(8'h85 + i);
      #1;
      chk("stream_data", out_data, 8'(8'h80 + i));
      tick();
      chk("stream_count", count, 5);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    // reset during simultaneous push and pop discards everything
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      tick();
    end
    chk("pre3_count", count, 3);
    nrst = 1'b0; in_data = 8'h77; out_ready = 1'b1;
    tick();
    nrst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("post_rst_head", out_data, 8'h5A);
    chk("post_rst_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_drained", empty, 1);
    // "HELLO" drained by a frame-paced consumer: one ready pulse per 10 cycles
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = hello[i];
      tick();
    end
    in_valid = 1'b0;
    chk("hello_count", count, 5);
    for (int k = 0; k < 5; k++) begin
      repeat (9) tick();
      chk("hello_hold", count, 5 - k);
      out_ready = 1'b1;
      #1;
      chk("hello_byte", out_data, hello[k]);
      tick();
      out_ready = 1'b0;
      chk("hello_dec", count, 4 - k);
    end
    chk("hello_empty", empty, 1);
    // empty FIFO offered a byte while the consumer is ready
    in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b1;
    #1;
`ifdef UART_TX_FIFO_BYPASS_EN
    chk("bypass_valid", out_valid, 1);
    chk("bypass_data", out_data, 8'h33);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bypass_count", count, 0);
    chk("bypass_empty", empty, 1);
`else
    chk("nobypass_valid", out_valid, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("nobypass_count", count, 1);
    chk("nobypass_data", out_data, 8'h33);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the byte producer (host logic, command/response formatter) and `uart_transmitter`. It decouples bursty producers from the serial line rate: the producer writes bytes at up to one per clock, and the transmitter drains them one per UART frame through its `valid`/`ready` handshake. It exposes fill status so software-facing logic can throttle or report backlog.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`, pointer index width; derived, never overridden.

- `clk`  in  1  system clock; all state updates on rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  producer offers `in_data`.
- `in_data`  in  8  byte to enqueue.
- `in_ready`  out  1  FIFO accepts a byte this cycle.
- `out_valid`  out  1  byte available on `out_data`; connects to transmitter `valid`.
- `out_data`  out  8  head byte; connects to transmitter `data`.
- `out_ready`  in  1  consumer takes head this cycle; connects to transmitter `ready`.
- `count`  out  AW+1  current number of stored entries, 0..DEPTH.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.

## Operation
- Storage: `DEPTH`×8 array, write pointer and read pointer each AW+1 bits (extra MSB is the wrap bit). Empty when pointers are equal; full when the low AW bits are equal and the MSBs differ.
- `count` = `wr_ptr - rd_ptr` modulo 2^(AW+1); registered behaviour follows the pointers.
- Push = `in_valid & in_ready`; writes `in_data` at `wr_ptr[AW-1:0]`, then `wr_ptr` increments.
- Pop = `out_valid & out_ready`; `rd_ptr` increments. Popped data is not cleared.
- `in_ready = nrst & ~full`. A push is never accepted when full, even if a pop occurs in the same cycle.
- `out_valid = ~empty` (see Configuration for the bypass case); `out_data = mem[rd_ptr[AW-1:0]]`, a combinational read.
- Simultaneous push and pop when neither full nor empty: both proceed, `count` unchanged.
- Pointer wrap: indices roll from DEPTH-1 to 0 while the MSB toggles; no special handling.
- `in_data` ignored when `in_valid` is low; `out_ready` ignored when `out_valid` is low.
- The consumer may hold `out_ready` high continuously. The transmitter asserts `ready` while idle and for one cycle at frame end. Either is a legal pop.

## Timing
- Reset (`nrst` low at a clock edge): pointers cleared to 0. After that edge: `count`=0, `empty`=1, `full`=0, `out_valid`=0. `in_ready` is 0 combinationally for as long as `nrst` is low. `out_data` is undefined until the first write.
- Reset asserted mid-operation discards all contents. Any push or pop in that cycle is ignored.
- Push latency (no bypass): a byte pushed at edge N is visible on `out_valid`/`out_data` after edge N, so a consumer can pop it at edge N+1.
- `count`, `empty` and `full` update on the edge of the push/pop that changes them.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `UART_TX_FIFO_BYPASS_EN` defined:
  - When empty, `out_valid = in_valid` and `out_data = in_data` (combinational cut-through).
  - If the FIFO is empty and the byte is taken in the same cycle (`in_valid & out_ready`), the byte is not stored, both pointers hold and `count` stays 0.
  - `in_ready` is unchanged.
- Undefined: no combinational path from `in_*` to `out_*`. Minimum latency is 1 cycle as in Timing.

## Test plan
- Reset, then idle: `count`=0, `empty`=1, `full`=0, `out_valid`=0, `in_ready`=1. Hold `nrst` low: `in_ready`=0.
- With `out_ready`=0, push 0x00..0x0F on 16 consecutive cycles (DEPTH=16) -> `full`=1, `count`=16, `in_ready`=0. A 17th byte 0xAA is not accepted.
- Drain the full FIFO with `out_ready`=1 -> `out_data` sequence 0x00..0x0F one per cycle, then `empty`=1.
- Continuous push and pop with `count`=5 over 40 cycles (pointers wrap twice) -> `count` stays 5, output order preserved.
- Connect to `uart_transmitter`, push "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) in 5 cycles -> the tx line emits 5 frames in order, and `count` decrements once per frame.
- Push 3 bytes, assert `nrst` low for 1 cycle during a simultaneous push and pop -> `count`=0, `out_valid`=0. A subsequent push of 0x5A appears at the head.
- Bypass only: push 0x33 with FIFO empty and `out_ready`=1 -> `out_valid`=1, `out_data`=0x33 in the same cycle, `count` stays 0.
